gcm_ae_deadlock_detector: RTL
=============================

Name: gcm_ae_deadlock_detector

Overview:
- Consumes the registered `block` outputs of the per-instance deadlock monitors in the GCM_AE_HW_1x1 core.
- Declares deadlock once at least one monitor stays blocked for THRESHOLD consecutive cycles with no dataflow progress.
- Latches which monitor was blocking, then offers a single report word to the debug/status path over a valid/ready handshake.
- Sits directly downstream of the monitor instances, one detector per core.

Parameters:
- N_MON, 7, number of monitor block inputs (bit i is monitor idx i).
- THRESHOLD, 16, consecutive blocked, no-progress cycles needed to declare deadlock; legal range 2..65535.
- IDX_W, 3, width of the reported index; must satisfy 2**IDX_W >= N_MON.

Ports:
- clock, input, 1, sole clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- mon_block, input, N_MON, block flags from the monitors, already registered by them.
- progress, input, 1, pulses high in any cycle in which any core stream handshake completes.
- clear, input, 1, synchronous software clear of a detected deadlock.
- deadlock, output, 1, sticky deadlock flag.
- deadlock_mask, output, N_MON, snapshot of mon_block taken on the detection cycle.
- deadlock_idx, output, IDX_W, index of the lowest set bit of deadlock_mask.
- rpt_valid, output, 1, report word valid.
- rpt_ready, input, 1, report consumer ready.
- rpt_data, output, IDX_W+N_MON, report word {deadlock_idx, deadlock_mask}.
- rpt_stamp, output, 32, detection cycle stamp (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0.
- blk = |mon_block & ~progress.
- Counter: width $clog2(THRESHOLD+1), saturating, never wraps.
- State IDLE:
  - blk=1 -> go to SUSPECT, cnt=1.
  - Otherwise cnt=0.
- State SUSPECT:
  - blk=0 -> go to IDLE, cnt=0. This covers a progress pulse and mon_block==0.
  - blk=1 and cnt==THRESHOLD-1 -> go to DEADLOCK. Same edge: deadlock<=1, deadlock_mask<=mon_block, deadlock_idx<=lowest set index of mon_block.
  - Otherwise cnt++.
- Detection timing: deadlock rises on the edge ending the THRESHOLD-th consecutive blk cycle. First blk at cycle 0 -> deadlock visible at cycle THRESHOLD.
- Mask content: a mask that shifts among bits while blk stays high still counts as continuous. Only the final cycle's mon_block is captured.
- State DEADLOCK:
  - deadlock stays 1.
  - Mask and idx are frozen; later mon_block changes are ignored.
  - Report handshake: rpt_valid goes 1 on the same edge deadlock rises. It holds, with rpt_data stable, until a cycle with rpt_valid & rpt_ready. It then drops to 0 on the next edge and never re-asserts for this event.
  - rpt_ready has no effect while rpt_valid=0.
- clear:
  - Any state -> IDLE on the next edge: cnt=0, deadlock=0, rpt_valid=0.
  - Mask and idx are zeroed.
  - clear has priority over detection in the same cycle, so detection is suppressed.
  - A pending unacknowledged report is discarded.
- After clear, a new detection needs a full fresh THRESHOLD run.
- reset mid-operation: same effect as clear, plus all registers return to their reset values.
- Simultaneous progress=1 and mon_block!=0: treated as not blocked, counter resets.
- There is no combinational path from inputs to outputs.

Optional Feature:
- Macro: GCM_AE_DEADLOCK_CYCLE_STAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter runs from reset; it is zeroed by reset only, not by clear, and wraps modulo 2**32.
  - rpt_stamp latches the counter value on the detection edge and holds it until clear or reset.
- Undefined: the counter is not built and rpt_stamp is constant 0. All other behaviour is identical.

Test Plan:
1. mon_block=7'b0000010, progress=0, held 16 cycles from cycle 0 -> deadlock=1 at cycle 16, idx=1, mask=7'b0000010, rpt_valid=1.
2. mon_block=7'b0000100 held 15 cycles, progress pulse at cycle 15, then blocked again -> no deadlock until 16 further blocked cycles, i.e. deadlock at cycle 32.
3. Deadlock with mask=7'b0110000 (idx=4), rpt_ready low 5 cycles then high 1 cycle -> rpt_data={3'd4,7'b0110000} stable throughout; rpt_valid low from the following cycle; deadlock remains 1.
4. clear asserted in the exact cycle the counter would hit THRESHOLD -> deadlock stays 0, state IDLE; a new 16-cycle run detects normally.
5. reset asserted while rpt_valid=1 -> all outputs 0 the next cycle; mon_block held blocked -> re-detection exactly 16 cycles after reset is released.
6. With GCM_AE_DEADLOCK_CYCLE_STAMP_EN defined, blocking starts at cycle 100 after reset -> rpt_stamp=115. Without the macro -> rpt_stamp=0.

Source files
------------

// File: rtl/gcm_ae_deadlock_detector.sv
// gcm_ae_deadlock_detector
//
// Watches the registered block flags of the GCM_AE_HW_1x1 deadlock monitors
// and declares a deadlock once at least one monitor has been blocked for
// THRESHOLD consecutive cycles with no dataflow progress. The blocking mask
// and its lowest set index are latched on the detection edge. They are then
// offered once to the debug/status path over a valid/ready handshake.
//
// Optional feature macro: GCM_AE_DEADLOCK_CYCLE_STAMP_EN
//   When defined, a free-running 32-bit cycle counter runs from reset.
//   rpt_stamp captures its value on the detection edge.
//   When undefined, rpt_stamp is tied to 0.
//
// Ports:
//   clock          sole clock, rising edge
//   reset          synchronous active-high reset
//   mon_block      per-monitor block flags (bit i = monitor i)
//   progress       high in any cycle with a completed stream handshake
//   clear          synchronous clear of a detected deadlock
//   deadlock       sticky deadlock flag
//   deadlock_mask  mon_block snapshot from the detection cycle
//   deadlock_idx   lowest set bit index of deadlock_mask
//   rpt_valid      report word valid
//   rpt_ready      report consumer ready
//   rpt_data       report word {deadlock_idx, deadlock_mask}
//   rpt_stamp      detection cycle stamp (0 when stamping is not built)
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | not blocked, counter at 0
// SUSPECT  | blocked for cnt consecutive cycles, below THRESHOLD
// DEADLOCK | deadlock declared; mask/idx frozen until clear or reset

module gcm_ae_deadlock_detector #(
    parameter int N_MON     = 7,
    parameter int THRESHOLD = 16,
    parameter int IDX_W     = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_MON-1:0]       mon_block,
    input  logic                   progress,
    input  logic                   clear,
    output logic                   deadlock,
    output logic [N_MON-1:0]       deadlock_mask,
    output logic [IDX_W-1:0]       deadlock_idx,
    output logic                   rpt_valid,
    input  logic                   rpt_ready,
    output logic [IDX_W+N_MON-1:0] rpt_data,
    output logic [31:0]            rpt_stamp
);

    localparam int CW = $clog2(THRESHOLD + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SUSPECT  = 2'd1,
        DEADLOCK = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          blk;
    logic          detect;

    // A progress pulse overrides any block flags in the same cycle.
    assign blk    = (|mon_block) & ~progress;
    assign detect = (state == SUSPECT) && blk && (cnt == CW'(THRESHOLD - 1));

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_MON-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        // Scan downward so the lowest set bit wins.
        for (int i = N_MON - 1; i >= 0; i--) begin
            if (m[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            // A clear overrides a detection that would happen in the same cycle.
            state         <= IDLE;
            cnt           <= '0;
            deadlock      <= 1'b0;
            deadlock_mask <= '0;
            deadlock_idx  <= '0;
            rpt_valid     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (blk) begin
                        state <= SUSPECT;
                        cnt   <= CW'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                SUSPECT: begin
                    if (!blk) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (detect) begin
                        state         <= DEADLOCK;
                        deadlock      <= 1'b1;
                        deadlock_mask <= mon_block;
                        deadlock_idx  <= lowest_idx(mon_block);
                        rpt_valid     <= 1'b1;
                    end else if (cnt != CW'(THRESHOLD)) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DEADLOCK: begin
                    // The report is offered once per event. The ready input
                    // has no effect once the report has been taken.
                    if (rpt_valid && rpt_ready) rpt_valid <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign rpt_data = {deadlock_idx, deadlock_mask};

`ifdef GCM_AE_DEADLOCK_CYCLE_STAMP_EN
    logic [31:0] cycle_cnt;
    logic [31:0] stamp;

    // The cycle counter is reset only by reset, never by clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt <= '0;
            stamp     <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (clear)       stamp <= '0;
            else if (detect) stamp <= cycle_cnt;
        end
    end

    assign rpt_stamp = stamp;
`else
    assign rpt_stamp = 32'd0;
`endif

endmodule
